// File: rtl/facto_core.sv
// facto_core: memory-mapped factorial accelerator, N! truncated to 128 bits via shift-add multiply.
// Define FACTO_CORE_INTR_EN to enable the INTR_EN register and the interrupt output.
module facto_core #(
    parameter logic [15:0] BASE_ADDR = 16'h7000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [15:0] s_addr,
    input  logic [63:0] s_din,
    output logic [63:0] s_dout,
    output logic        interrupt
);
    localparam logic [15:0] A_START = BASE_ADDR,
                            A_CLEAR = BASE_ADDR + 16'h08,
                            A_DONE  = BASE_ADDR + 16'h10,
                            A_INTR  = BASE_ADDR + 16'h18,
                            A_OPND  = BASE_ADDR + 16'h20,
                            A_RH    = BASE_ADDR + 16'h28,
                            A_RL    = BASE_ADDR + 16'h30;

    typedef enum logic [1:0] {IDLE, CHECK, MUL, DONE} state_t;
    state_t state, next;

    logic         opclear, intr_en;
    logic [63:0]  operand, counter, mplier;
    logic [127:0] result, mcand, acc, acc_next;
    logic [5:0]   bitcnt;
    logic [63:0]  rdata;

    logic wr, busy, done, start, clr;
    assign wr    = s_sel & s_wr;
    assign busy  = (state == CHECK) | (state == MUL);
    assign done  = state == DONE;
    assign start = wr && s_addr == A_START && s_din[0];
    // A clear write acts on its own edge, not one cycle later
    assign clr   = opclear | (wr && s_addr == A_CLEAR && s_din[0]);
    assign acc_next = acc + (mplier[0] ? mcand : 128'd0);
    assign interrupt = done & intr_en;

    always_ff @(posedge clk)
        if (reset) begin
            opclear <= 1'b0;
            operand <= 64'd0;
        end else begin
            if (wr && s_addr == A_CLEAR) opclear <= s_din[0];
            if (wr && s_addr == A_OPND && !busy) operand <= s_din;
        end

`ifdef FACTO_CORE_INTR_EN
    always_ff @(posedge clk)
        if (reset) intr_en <= 1'b0;
        else if (wr && s_addr == A_INTR) intr_en <= s_din[0];
`else
    assign intr_en = 1'b0;
`endif

    always_ff @(posedge clk)
        state <= reset ? IDLE : next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? CHECK : IDLE;
            CHECK:   next = (counter <= 64'd1) ? DONE : MUL;
            MUL:     next = (bitcnt == 6'd63) ? CHECK : MUL;
            default: next = state;
        endcase
        if (clr) next = IDLE;
    end

    always_ff @(posedge clk)
        if (reset || clr) begin
            counter <= 64'd0;
            mplier  <= 64'd0;
            result  <= 128'd0;
            mcand   <= 128'd0;
            acc     <= 128'd0;
            bitcnt  <= 6'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    counter <= operand;
                    result  <= 128'd1;
                end
                CHECK: if (counter > 64'd1) begin
                    mcand  <= result;
                    mplier <= counter;
                    acc    <= 128'd0;
                    bitcnt <= 6'd0;
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    bitcnt <= bitcnt + 6'd1;
                    if (bitcnt == 6'd63) begin
                        result  <= acc_next;
                        counter <= counter - 64'd1;
                    end
                end
                default: ;
            endcase
        end

    always_comb begin
        rdata = 64'd0;
        case (s_addr)
            A_CLEAR: rdata = {63'd0, opclear};
            A_DONE:  rdata = {62'd0, busy, done};
            A_INTR:  rdata = {63'd0, intr_en};
            A_OPND:  rdata = operand;
            A_RH:    rdata = result[127:64];
            A_RL:    rdata = result[63:0];
            default: rdata = 64'd0;
        endcase
        s_dout = (s_sel && !s_wr) ? rdata : 64'd0;
    end
endmodule

// File: tb/tb_facto_core.sv
// tb_facto_core: directed register-level checks of facto_core latency, results, clear and interrupt.
module tb_facto_core;
    localparam logic [15:0] A_START = 16'h7000, A_CLEAR = 16'h7008, A_DONE = 16'h7010,
                            A_INTR = 16'h7018, A_OPND = 16'h7020, A_RH = 16'h7028,
                            A_RL = 16'h7030, A_NONE = 16'h7038;
`ifdef FACTO_CORE_INTR_EN
    localparam logic HAS_INTR = 1'b1;
`else
    localparam logic HAS_INTR = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1, s_sel = 1'b0, s_wr = 1'b0, interrupt;
    logic [15:0] s_addr = 16'd0;
    logic [63:0] s_din = 64'd0, s_dout, d;
    logic [127:0] f100;
    int vectors = 0, errors = 0, cyc = 0, t0;

    facto_core dut (.clk(clk), .reset(reset), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr),
                    .s_din(s_din), .s_dout(s_dout), .interrupt(interrupt));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] fact(input int n);
        logic [127:0] m = 128'd1;
        for (int i = 2; i <= n; i++) m = m * 128'(i);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] v);
        @(negedge clk);
        s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = v;
        @(posedge clk); #1;
        s_sel = 1'b0; s_wr = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [63:0] v);
        s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
        #1 v = s_dout;
        s_sel = 1'b0;
    endtask

    task automatic run(input logic [63:0] n);
        wr(A_OPND, n);
        wr(A_START, 64'd1);
        t0 = cyc;
    endtask

    task automatic wait_done(input string tag, input int lat);
        logic [63:0] v = 64'd0;
        bit busy_ok = 1'b1;
        while (v[0] !== 1'b1 && cyc - t0 < 8000) begin
            @(posedge clk); #1;
            rd(A_DONE, v);
            if (v[0] !== 1'b1 && v[1] !== 1'b1) busy_ok = 1'b0;
        end
        chk({tag, "_latency"}, 128'(cyc - t0), 128'(lat));
        chk({tag, "_busy"}, 128'(busy_ok), 128'd1);
        chk({tag, "_opdone"}, 128'(v), 128'd1);
    endtask

    task automatic clear();
        wr(A_CLEAR, 64'd1);
        wr(A_CLEAR, 64'd0);
    endtask

    initial begin
        f100 = fact(100);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        rd(A_DONE, d);     chk("rst_opdone", 128'(d), 128'd0);
        rd(A_RL, d);       chk("rst_result_l", 128'(d), 128'd0);
        rd(A_OPND, d);     chk("rst_operand", 128'(d), 128'd0);
        chk("rst_intr", 128'(interrupt), 128'd0);
        s_addr = A_OPND; #1;
        chk("idle_dout", 128'(s_dout), 128'd0);

        wr(A_INTR, 64'd1);
        rd(A_INTR, d);     chk("intr_en_rb", 128'(d), 128'(HAS_INTR));
        run(64'd0);
        wait_done("n0", 1);
        chk("n0_intr", 128'(interrupt), 128'(HAS_INTR));
        rd(A_RH, d);       chk("n0_result_h", 128'(d), 128'd0);
        rd(A_RL, d);       chk("n0_result_l", 128'(d), 128'd1);

        wr(A_CLEAR, 64'd1);
        chk("clr_intr_fall", 128'(interrupt), 128'd0);
        rd(A_CLEAR, d);    chk("clr_readback", 128'(d), 128'd1);
        wr(A_CLEAR, 64'd0);
        run(64'd2);
        wait_done("n2", 66);
        rd(A_RL, d);       chk("n2_result_l", 128'(d), 128'd2);
        chk("n2_intr", 128'(interrupt), 128'(HAS_INTR));
        clear();
        chk("n2_clr_intr", 128'(interrupt), 128'd0);
        rd(A_RL, d);       chk("n2_clr_result_l", 128'(d), 128'd0);
        rd(A_DONE, d);     chk("n2_clr_opdone", 128'(d), 128'd0);

        run(64'd5);
        wait_done("n5", 261);
        rd(A_RL, d);       chk("n5_result_l", 128'(d), 128'd120);
        rd(A_RH, d);       chk("n5_result_h", 128'(d), 128'd0);
        clear();

        run(64'd21);
        wait_done("n21", 1301);
        rd(A_RH, d);       chk("n21_result_h", 128'(d), 128'd2);
        rd(A_RL, d);       chk("n21_result_l", 128'(d), 128'd14197454024290336768);
        clear();

        run(64'd100);
        wr(A_OPND, 64'd7);
        wr(A_START, 64'd1);
        rd(A_OPND, d);     chk("n100_operand_locked", 128'(d), 128'd100);
        wait_done("n100", 6436);
        rd(A_RH, d);       chk("n100_result_h", 128'(d), 128'(f100[127:64]));
        rd(A_RL, d);       chk("n100_result_l", 128'(d), 128'(f100[63:0]));
        wr(A_START, 64'd1);
        rd(A_DONE, d);     chk("done_start_ignored", 128'(d), 128'd1);
        rd(A_RH, d);       chk("done_result_held", 128'(d), 128'(f100[127:64]));
        clear();

        wr(A_INTR, 64'd0);
        run(64'd5);
        wait_done("n5_poll", 261);
        chk("n5_poll_intr", 128'(interrupt), 128'd0);
        clear();
        run(64'd5);
        repeat (20) @(posedge clk);
        #1;
        rd(A_DONE, d);     chk("abort_busy_before", 128'(d), 128'd2);
        wr(A_CLEAR, 64'd1);
        rd(A_DONE, d);     chk("abort_opdone", 128'(d), 128'd0);
        rd(A_RL, d);       chk("abort_result_l", 128'(d), 128'd0);
        wr(A_CLEAR, 64'd0);
        repeat (5) @(posedge clk);
        #1;
        rd(A_DONE, d);     chk("abort_stays_idle", 128'(d), 128'd0);

        rd(A_NONE, d);     chk("unmapped_read", 128'(d), 128'd0);
        rd(A_START, d);    chk("opstart_read", 128'(d), 128'd0);
        rd(A_OPND, d);     chk("operand_kept", 128'(d), 128'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
